// File: rtl/id_ex_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_ctrl_pipe
// Description : Registered RV32I decode/control stage. Decodes the IF/ID
//               instruction into control strobes and register fields and
//               holds them in an ID/EX register with valid/ready handshakes
//               on both sides. Adds load-use interlock (bubble insertion),
//               flush, rd==x0 write suppression, AUIPC via the ALU with a PC
//               operand, CSR decode and a saturating interlock counter.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n            : rising-edge clock, asynchronous active-low reset
//   flush                 : kill the ID/EX contents and the current input
//   if_valid / if_ready   : upstream handshake (instruction offered/accepted)
//   if_instr, if_pc       : instruction word and its PC
//   ex_valid / ex_ready   : downstream handshake (register live/consumed)
//   ex_pc                 : registered PC
//   ex_rd/rs1/rs2/func3   : register fields of the held instruction
//   ex_reg_write .. csr_we: control strobes (forced 0 while ex_valid=0)
//   ex_alu_fun            : ALU function code, zero-filled above bit 3
//   ex_immed_sel          : 000 I, 001 S, 010 B, 011 J, 100 U
//   ex_rf_wr_sel          : 00 PC+4, 01 CSR, 10 memory, 11 ALU
//   ex_srcA_sel/srcB_sel  : operand A 0 rs1/1 PC, operand B 0 rs2/1 imm
//   ex_illegal            : undecodable instruction
//   stall_cnt             : saturating count of interlock bubbles
// Configuration
//   ID_EX_ILLEGAL_TRAP_EN : when defined, unknown opcodes, instr[1:0]!=11 and
//                           OP with a non-standard funct7 raise ex_illegal
//                           and have all strobes cleared. When undefined,
//                           ex_illegal is 0 and unknown opcodes take the
//                           default decode.
// ============================================================================
module id_ex_ctrl_pipe #(
  parameter int XLEN      = 32,
  parameter int ALU_FUN_W = 4,
  parameter int CNT_W     = 16,
  parameter int HAZARD_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 if_valid,
  output logic                 if_ready,
  input  logic [31:0]          if_instr,
  input  logic [XLEN-1:0]      if_pc,
  output logic                 ex_valid,
  input  logic                 ex_ready,
  output logic [XLEN-1:0]      ex_pc,
  output logic [4:0]           ex_rd,
  output logic [4:0]           ex_rs1,
  output logic [4:0]           ex_rs2,
  output logic [2:0]           ex_func3,
  output logic                 ex_reg_write,
  output logic                 ex_mem_write,
  output logic                 ex_mem_read,
  output logic                 ex_jump,
  output logic                 ex_branch,
  output logic                 ex_csr_we,
  output logic [ALU_FUN_W-1:0] ex_alu_fun,
  output logic [2:0]           ex_immed_sel,
  output logic [1:0]           ex_rf_wr_sel,
  output logic                 ex_srcA_sel,
  output logic                 ex_srcB_sel,
  output logic                 ex_illegal,
  output logic [CNT_W-1:0]     stall_cnt
);

  // Opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Immediate selects
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Writeback selects
  localparam logic [1:0] WB_PC4 = 2'b00;
  localparam logic [1:0] WB_CSR = 2'b01;
  localparam logic [1:0] WB_MEM = 2'b10;
  localparam logic [1:0] WB_ALU = 2'b11;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_PASSB = 4'b1001;

  // --------------------------------------------------------------------------
  // Instruction fields
  // --------------------------------------------------------------------------
  logic [6:0] w_opcode;
  logic [4:0] w_rd;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic [2:0] w_func3;
  logic       w_f7b5;

  assign w_opcode = if_instr[6:0];
  assign w_rd     = if_instr[11:7];
  assign w_func3  = if_instr[14:12];
  assign w_rs1    = if_instr[19:15];
  assign w_rs2    = if_instr[24:20];
  assign w_f7b5   = if_instr[30];

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic       w_reg_write;
  logic       w_mem_write;
  logic       w_mem_read;
  logic       w_jump;
  logic       w_branch;
  logic       w_csr_we;
  logic [3:0] w_alu;
  logic [2:0] w_immed_sel;
  logic [1:0] w_rf_wr_sel;
  logic       w_srcA_sel;
  logic       w_srcB_sel;
  logic       w_illegal;
  logic       w_use_rs1;
  logic       w_use_rs2;

  always_comb begin
    w_reg_write = 1'b1;
    w_mem_write = 1'b0;
    w_mem_read  = 1'b0;
    w_jump      = 1'b0;
    w_branch    = 1'b0;
    w_csr_we    = 1'b0;
    w_alu       = ALU_ADD;
    w_immed_sel = IMM_I;
    w_rf_wr_sel = WB_ALU;
    w_srcA_sel  = 1'b0;
    w_srcB_sel  = 1'b0;
    w_illegal   = 1'b0;
    w_use_rs1   = 1'b1;
    w_use_rs2   = 1'b0;

    case (w_opcode)
      OPC_LUI: begin
        w_alu       = ALU_PASSB;
        w_immed_sel = IMM_U;
        w_srcB_sel  = 1'b1;
        w_use_rs1   = 1'b0;
      end
      OPC_AUIPC: begin
        // PC + U-immediate computed by the ALU's adder
        w_immed_sel = IMM_U;
        w_srcA_sel  = 1'b1;
        w_srcB_sel  = 1'b1;
        w_use_rs1   = 1'b0;
      end
      OPC_JAL: begin
        w_jump      = 1'b1;
        w_immed_sel = IMM_J;
        w_rf_wr_sel = WB_PC4;
        w_use_rs1   = 1'b0;
      end
      OPC_JALR: begin
        w_jump      = 1'b1;
        w_rf_wr_sel = WB_PC4;
        w_srcB_sel  = 1'b1;
      end
      OPC_BRANCH: begin
        w_reg_write = 1'b0;
        w_branch    = 1'b1;
        w_immed_sel = IMM_B;
        w_use_rs2   = 1'b1;
      end
      OPC_LOAD: begin
        w_mem_read  = 1'b1;
        w_srcB_sel  = 1'b1;
        w_rf_wr_sel = WB_MEM;
      end
      OPC_STORE: begin
        w_reg_write = 1'b0;
        w_mem_write = 1'b1;
        w_immed_sel = IMM_S;
        w_srcB_sel  = 1'b1;
        w_use_rs2   = 1'b1;
      end
      OPC_OP_IMM: begin
        // Only shifts (func3=101) carry an ALU-relevant bit 30 (SRLI/SRAI)
        if (w_func3 == 3'b101) begin
          w_alu = {w_f7b5, w_func3};
        end else begin
          w_alu = {1'b0, w_func3};
        end
        w_srcB_sel = 1'b1;
      end
      OPC_OP: begin
        w_alu     = {w_f7b5, w_func3};
        w_use_rs2 = 1'b1;
`ifdef ID_EX_ILLEGAL_TRAP_EN
        if ((if_instr[31:25] != 7'b0000000) && (if_instr[31:25] != 7'b0100000)) begin
          w_illegal = 1'b1;
        end
`endif
      end
      OPC_SYSTEM: begin
        if (w_func3 != 3'b000) begin
          w_csr_we    = 1'b1;
          w_rf_wr_sel = WB_CSR;
        end else begin
          w_reg_write = 1'b0;
        end
      end
      default: begin
`ifdef ID_EX_ILLEGAL_TRAP_EN
        w_illegal = 1'b1;
`endif
      end
    endcase

`ifdef ID_EX_ILLEGAL_TRAP_EN
    if (if_instr[1:0] != 2'b11) begin
      w_illegal = 1'b1;
    end
    if (w_illegal) begin
      w_reg_write = 1'b0;
      w_mem_write = 1'b0;
      w_mem_read  = 1'b0;
      w_jump      = 1'b0;
      w_branch    = 1'b0;
      w_csr_we    = 1'b0;
    end
`endif

    // x0 is hardwired zero; never request a write to it
    if (w_rd == 5'd0) begin
      w_reg_write = 1'b0;
    end
  end

  logic [ALU_FUN_W-1:0] w_alu_ext;
  always_comb begin
    w_alu_ext      = '0;
    w_alu_ext[3:0] = w_alu;
  end

  // --------------------------------------------------------------------------
  // ID/EX register state
  // --------------------------------------------------------------------------
  logic                 r_valid;
  logic [XLEN-1:0]      r_pc;
  logic [4:0]           r_rd;
  logic [4:0]           r_rs1;
  logic [4:0]           r_rs2;
  logic [2:0]           r_func3;
  logic                 r_reg_write;
  logic                 r_mem_write;
  logic                 r_mem_read;
  logic                 r_jump;
  logic                 r_branch;
  logic                 r_csr_we;
  logic [ALU_FUN_W-1:0] r_alu;
  logic [2:0]           r_immed_sel;
  logic [1:0]           r_rf_wr_sel;
  logic                 r_srcA_sel;
  logic                 r_srcB_sel;
  logic                 r_illegal;
  logic [CNT_W-1:0]     r_stall_cnt;

  // --------------------------------------------------------------------------
  // Handshake and load-use interlock
  // --------------------------------------------------------------------------
  logic w_advance;
  logic w_hazard_raw;
  logic w_hazard;

  assign w_advance = !r_valid || ex_ready;

  // A load in EX whose destination is a source of the incoming instruction.
  // The bubble lets the load move on so its data can be forwarded next cycle.
  assign w_hazard_raw = r_valid && r_mem_read && (r_rd != 5'd0) && if_valid &&
                        ((w_use_rs1 && (w_rs1 == r_rd)) ||
                         (w_use_rs2 && (w_rs2 == r_rd)));

  generate
    if (HAZARD_EN != 0) begin : g_hazard
      assign w_hazard = w_hazard_raw;
    end else begin : g_no_hazard
      assign w_hazard = 1'b0;
    end
  endgenerate

  assign if_ready = flush || (w_advance && !w_hazard);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_rd        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_func3     <= '0;
      r_reg_write <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_jump      <= 1'b0;
      r_branch    <= 1'b0;
      r_csr_we    <= 1'b0;
      r_alu       <= '0;
      r_immed_sel <= '0;
      r_rf_wr_sel <= '0;
      r_srcA_sel  <= 1'b0;
      r_srcB_sel  <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (flush) begin
      // Input is consumed and dropped together with the register contents
      r_valid <= 1'b0;
    end else if (w_advance) begin
      if (w_hazard) begin
        r_valid <= 1'b0;
      end else if (if_valid) begin
        r_valid     <= 1'b1;
        r_pc        <= if_pc;
        r_rd        <= w_rd;
        r_rs1       <= w_rs1;
        r_rs2       <= w_rs2;
        r_func3     <= w_func3;
        r_reg_write <= w_reg_write;
        r_mem_write <= w_mem_write;
        r_mem_read  <= w_mem_read;
        r_jump      <= w_jump;
        r_branch    <= w_branch;
        r_csr_we    <= w_csr_we;
        r_alu       <= w_alu_ext;
        r_immed_sel <= w_immed_sel;
        r_rf_wr_sel <= w_rf_wr_sel;
        r_srcA_sel  <= w_srcA_sel;
        r_srcB_sel  <= w_srcB_sel;
        r_illegal   <= w_illegal;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  // Counts bubble cycles only; a flush takes priority and is not counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (!flush && w_advance && w_hazard && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: strobes are qualified with valid so a stale payload never acts
  // --------------------------------------------------------------------------
  assign ex_valid     = r_valid;
  assign ex_pc        = r_pc;
  assign ex_rd        = r_rd;
  assign ex_rs1       = r_rs1;
  assign ex_rs2       = r_rs2;
  assign ex_func3     = r_func3;
  assign ex_reg_write = r_valid && r_reg_write;
  assign ex_mem_write = r_valid && r_mem_write;
  assign ex_mem_read  = r_valid && r_mem_read;
  assign ex_jump      = r_valid && r_jump;
  assign ex_branch    = r_valid && r_branch;
  assign ex_csr_we    = r_valid && r_csr_we;
  assign ex_alu_fun   = r_alu;
  assign ex_immed_sel = r_immed_sel;
  assign ex_rf_wr_sel = r_rf_wr_sel;
  assign ex_srcA_sel  = r_srcA_sel;
  assign ex_srcB_sel  = r_srcB_sel;
  assign ex_illegal   = r_illegal;
  assign stall_cnt    = r_stall_cnt;

  // Instruction bits not consumed by the decode in every configuration
  logic w_unused;
  assign w_unused = ^{if_instr[31], if_instr[29:25], if_instr[1:0], w_hazard_raw};

endmodule
`default_nettype wire

// File: tb/tb_id_ex_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_ctrl_pipe
// Description : Table-driven bench for id_ex_ctrl_pipe: decode vectors with
//               hand-computed control words, plus directed sequences for
//               load-use bubbles, x0 handling, back-pressure, flush and
//               asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_ctrl_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2;
  logic [2:0]  ex_func3;
  logic        ex_reg_write, ex_mem_write, ex_mem_read, ex_jump, ex_branch, ex_csr_we;
  logic [3:0]  ex_alu_fun;
  logic [2:0]  ex_immed_sel;
  logic [1:0]  ex_rf_wr_sel;
  logic        ex_srcA_sel, ex_srcB_sel, ex_illegal;
  logic [15:0] stall_cnt;

  id_ex_ctrl_pipe #(
    .XLEN(32), .ALU_FUN_W(4), .CNT_W(16), .HAZARD_EN(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
    .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_func3(ex_func3),
    .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write), .ex_mem_read(ex_mem_read),
    .ex_jump(ex_jump), .ex_branch(ex_branch), .ex_csr_we(ex_csr_we),
    .ex_alu_fun(ex_alu_fun), .ex_immed_sel(ex_immed_sel), .ex_rf_wr_sel(ex_rf_wr_sel),
    .ex_srcA_sel(ex_srcA_sel), .ex_srcB_sel(ex_srcB_sel), .ex_illegal(ex_illegal),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected word layout: {rw,mw,mr,jump,branch,csr_we,illegal, alu[3:0],
  //                        immed[2:0], rf_wr_sel[1:0], srcA, srcB,
  //                        rd[4:0], rs1[4:0], rs2[4:0], func3[2:0]}
  typedef struct {
    logic [31:0] instr;
    logic [35:0] exp;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  function automatic logic [35:0] act_word();
    return {ex_reg_write, ex_mem_write, ex_mem_read, ex_jump, ex_branch, ex_csr_we,
            ex_illegal, ex_alu_fun, ex_immed_sel, ex_rf_wr_sel, ex_srcA_sel,
            ex_srcB_sel, ex_rd, ex_rs1, ex_rs2, ex_func3};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr);
    if_instr = instr;
    if_valid = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // addi x5,x0,7
    vecs[0]  = '{32'h00700293, {7'b1000000, 4'b0000, 3'b000, 2'b11, 1'b0, 1'b1, 5'd5,  5'd0, 5'd7,  3'd0}};
    // lui x3,0x12345
    vecs[1]  = '{32'h123451B7, {7'b1000000, 4'b1001, 3'b100, 2'b11, 1'b0, 1'b1, 5'd3,  5'd8, 5'd3,  3'd5}};
    // auipc x4,1
    vecs[2]  = '{32'h00001217, {7'b1000000, 4'b0000, 3'b100, 2'b11, 1'b1, 1'b1, 5'd4,  5'd0, 5'd0,  3'd1}};
    // jal x1,8
    vecs[3]  = '{32'h008000EF, {7'b1001000, 4'b0000, 3'b011, 2'b00, 1'b0, 1'b0, 5'd1,  5'd0, 5'd8,  3'd0}};
    // jalr x0,0(x1): rd=x0 so no register write
    vecs[4]  = '{32'h00008067, {7'b0001000, 4'b0000, 3'b000, 2'b00, 1'b0, 1'b1, 5'd0,  5'd1, 5'd0,  3'd0}};
    // beq x1,x2,8
    vecs[5]  = '{32'h00208463, {7'b0000100, 4'b0000, 3'b010, 2'b11, 1'b0, 1'b0, 5'd8,  5'd1, 5'd2,  3'd0}};
    // sw x2,4(x1)
    vecs[6]  = '{32'h0020A223, {7'b0100000, 4'b0000, 3'b001, 2'b11, 1'b0, 1'b1, 5'd4,  5'd1, 5'd2,  3'd2}};
    // lw x6,0(x1)
    vecs[7]  = '{32'h0000A303, {7'b1010000, 4'b0000, 3'b000, 2'b10, 1'b0, 1'b1, 5'd6,  5'd1, 5'd0,  3'd2}};
    // srai x9,x8,3 (does not read x6: no interlock behind the lw)
    vecs[8]  = '{32'h40345493, {7'b1000000, 4'b1101, 3'b000, 2'b11, 1'b0, 1'b1, 5'd9,  5'd8, 5'd3,  3'd5}};
    // sub x7,x6,x2
    vecs[9]  = '{32'h402303B3, {7'b1000000, 4'b1000, 3'b000, 2'b11, 1'b0, 1'b0, 5'd7,  5'd6, 5'd2,  3'd0}};
    // csrrw x5,mstatus,x1
    vecs[10] = '{32'h300092F3, {7'b1000010, 4'b0000, 3'b000, 2'b01, 1'b0, 1'b0, 5'd5,  5'd1, 5'd0,  3'd1}};
    // ecall
    vecs[11] = '{32'h00000073, {7'b0000000, 4'b0000, 3'b000, 2'b11, 1'b0, 1'b0, 5'd0,  5'd0, 5'd0,  3'd0}};
    // unknown opcode 0x7F, rd=x1
`ifdef ID_EX_ILLEGAL_TRAP_EN
    vecs[12] = '{32'h000000FF, {7'b0000001, 4'b0000, 3'b000, 2'b11, 1'b0, 1'b0, 5'd1,  5'd0, 5'd0,  3'd0}};
`else
    vecs[12] = '{32'h000000FF, {7'b1000000, 4'b0000, 3'b000, 2'b11, 1'b0, 1'b0, 5'd1,  5'd0, 5'd0,  3'd0}};
`endif
    // slti x10,x1,-1
    vecs[13] = '{32'hFFF0A513, {7'b1000000, 4'b0010, 3'b000, 2'b11, 1'b0, 1'b1, 5'd10, 5'd1, 5'd31, 3'd2}};
    // or x11,x1,x2
    vecs[14] = '{32'h0020E5B3, {7'b1000000, 4'b0110, 3'b000, 2'b11, 1'b0, 1'b0, 5'd11, 5'd1, 5'd2,  3'd6}};

    rst_n    = 1'b0;
    flush    = 1'b0;
    if_valid = 1'b0;
    if_instr = 32'h0;
    if_pc    = 32'h0;
    ex_ready = 1'b1;
    tick();
    tick();
    chk("reset_ctrl", 64'(act_word()), 64'(0));
    chk("reset_valid_pc", 64'({ex_valid, ex_pc}), 64'(0));
    chk("reset_stall_cnt", 64'(stall_cnt), 64'(0));
    chk("reset_if_ready", 64'(if_ready), 64'(1));
    rst_n = 1'b1;
    tick();

    // ---------------- decode table, streamed back to back ----------------
    for (int i = 0; i < NV; i++) begin
      offer(vecs[i].instr);
      if_pc = 32'h100 + 32'(4 * i);
      #1;
      chk($sformatf("vec%0d_if_ready", i), 64'(if_ready), 64'(1));
      tick();
      chk($sformatf("vec%0d_ctrl", i), 64'(act_word()), 64'(vecs[i].exp));
      chk($sformatf("vec%0d_valid_pc", i), 64'({ex_valid, ex_pc}),
          64'({1'b1, 32'h100 + 32'(4 * i)}));
    end
    if_valid = 1'b0;
    tick();
    chk("drain_valid", 64'(ex_valid), 64'(0));
    chk("no_stall_yet", 64'(stall_cnt), 64'(0));

    // ---------------- lw x6 ; add x7,x6,x2 -> one bubble ----------------
    offer(32'h0000A303);
    tick();
    offer(32'h002303B3);
    #1;
    chk("lu_if_ready_low", 64'(if_ready), 64'(0));
    tick();
    chk("lu_bubble", 64'({ex_valid, stall_cnt}), 64'({1'b0, 16'd1}));
    chk("lu_retry_ready", 64'(if_ready), 64'(1));
    tick();
    chk("lu_add_issued", 64'({ex_valid, ex_reg_write, ex_rd, ex_rs1}),
        64'({1'b1, 1'b1, 5'd7, 5'd6}));
    if_valid = 1'b0;
    tick();

    // ---------------- lw x6 ; addi x0,x6,1 -> bubble, no write ----------------
    offer(32'h0000A303);
    tick();
    offer(32'h00130013);
    #1;
    chk("lu0_if_ready_low", 64'(if_ready), 64'(0));
    tick();
    chk("lu0_bubble", 64'({ex_valid, stall_cnt}), 64'({1'b0, 16'd2}));
    tick();
    chk("lu0_addi_x0", 64'({ex_valid, ex_reg_write, ex_rd}), 64'({1'b1, 1'b0, 5'd0}));

    // ---------------- lw x0 ; addi x1,x0,1 -> no bubble ----------------
    offer(32'h0000A003);
    tick();
    offer(32'h00100093);
    #1;
    chk("lwx0_if_ready", 64'(if_ready), 64'(1));
    tick();
    chk("lwx0_no_bubble", 64'({ex_valid, ex_rd, stall_cnt}), 64'({1'b1, 5'd1, 16'd2}));

    // ---------------- back-pressure: hold add for 3 cycles ----------------
    offer(32'h002303B3);
    tick();
    ex_ready = 1'b0;
    offer(32'h00700293);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("hold%0d_if_ready", k), 64'(if_ready), 64'(0));
      tick();
      chk($sformatf("hold%0d_outputs", k), 64'({ex_valid, ex_reg_write, ex_rd, ex_rs1, ex_alu_fun}),
          64'({1'b1, 1'b1, 5'd7, 5'd6, 4'b0000}));
    end
    ex_ready = 1'b1;
    #1;
    chk("release_if_ready", 64'(if_ready), 64'(1));
    tick();
    chk("release_next", 64'({ex_valid, ex_rd, ex_srcB_sel}), 64'({1'b1, 5'd5, 1'b1}));

    // ---------------- flush over a load-use hazard ----------------
    offer(32'h0000A303);
    tick();
    offer(32'h002303B3);
    flush = 1'b1;
    #1;
    chk("flush_if_ready", 64'(if_ready), 64'(1));
    tick();
    chk("flush_result", 64'({ex_valid, ex_reg_write, stall_cnt}), 64'({1'b0, 1'b0, 16'd2}));
    flush    = 1'b0;
    if_valid = 1'b0;
    tick();

    // ---------------- asynchronous reset mid-cycle ----------------
    offer(32'h00700293);
    tick();
    chk("pre_reset_valid", 64'(ex_valid), 64'(1));
    if_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 64'({ex_valid, ex_reg_write, ex_rd, stall_cnt}), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_ctrl_pipe.md
Name: id_ex_ctrl_pipe

Overview:
Registered decode/control stage for the RV32I pipeline. It sits between the IF/ID register and EX, and turns each fetched instruction into control signals plus register fields. Results are held in an ID/EX register with valid/ready handshakes on both sides. Compared with the purely combinational decoder, it adds:
- load-use interlock (bubble insertion)
- synchronous flush for taken branches and jumps
- rd==x0 write suppression
- AUIPC through the ALU with a PC operand
- CSR decode
- a saturating stall counter

Parameters:
XLEN, 32, width of PC.
ALU_FUN_W, 4, width of ALU function code; must be at least 4, and upper bits above 3 are zero-filled.
CNT_W, 16, width of stall counter.
HAZARD_EN, 1, 1 enables load-use interlock; 0 means in_ready ignores hazards.

Ports:
clk in 1 rising-edge clock
rst_n in 1 asynchronous active-low reset
flush in 1 kill the EX-register contents and the current input instruction
if_valid in 1 IF/ID holds an instruction
if_ready out 1 stage accepts the instruction this cycle
if_instr in 32 instruction word
if_pc in XLEN PC of the instruction
ex_valid out 1 ID/EX register holds a live instruction
ex_ready in 1 EX consumes the register this cycle
ex_pc out XLEN registered PC
ex_rd, ex_rs1, ex_rs2 out 5 each, register fields instr[11:7], [19:15], [24:20]
ex_func3 out 3 instr[14:12]
ex_reg_write, ex_mem_write, ex_mem_read, ex_jump, ex_branch, ex_csr_we out 1 each, control strobes
ex_alu_fun out ALU_FUN_W ALU function code
ex_immed_sel out 3 immediate type: 000 I, 001 S, 010 B, 011 J, 100 U
ex_rf_wr_sel out 2 writeback source: 00 PC+4, 01 CSR, 10 memory, 11 ALU
ex_srcA_sel out 1 ALU operand A: 0 rs1, 1 PC
ex_srcB_sel out 1 ALU operand B: 0 rs2, 1 immediate
ex_illegal out 1 undecodable instruction (see Optional Feature)
stall_cnt out CNT_W count of interlock bubbles, saturating

Behaviour:
- Reset (rst_n=0, asynchronous): every ex_* output is 0 and stall_cnt is 0; if_ready follows its equation.
- Default decode: reg_write=1, alu 0000, immed I, rf_wr_sel 11, all other strobes 0.
- LUI: alu 1001 (pass B), immed U, srcB 1.
- AUIPC: alu 0000, immed U, srcA 1, srcB 1.
- JAL: jump, immed J, rf_wr_sel 00.
- JALR: jump, immed I, rf_wr_sel 00, srcB 1.
- BRANCH: reg_write 0, branch, immed B.
- LOAD: mem_read, srcB 1, rf_wr_sel 10.
- STORE: reg_write 0, mem_write, immed S, srcB 1.
- OP_IMM: alu={func7b5,func3} if func3=101, else {0,func3}; srcB 1.
- OP: alu={instr[30],func3}.
- SYSTEM: if func3≠000 then csr_we=1 and rf_wr_sel 01; if func3=000 then reg_write 0.
- x0 suppression: when rd=0, ex_reg_write=0 regardless of opcode.
- Operand usage:
  - rs1 is used by every opcode except LUI, AUIPC and JAL.
  - rs2 is used by BRANCH, STORE and OP.
- hazard (HAZARD_EN=1): ex_valid & ex_mem_read & ex_rd≠0 & if_valid & one of:
  - rs1 is used and if_instr rs1=ex_rd
  - rs2 is used and if_instr rs2=ex_rd
- advance = !ex_valid | ex_ready.
- if_ready = flush | (advance & !hazard).
- Register update on each rising edge, priority order:
  1. flush: ex_valid←0. The input is consumed and discarded even if if_valid=1.
  2. advance & hazard: bubble, ex_valid←0. The load moves downstream; the instruction retries next cycle, when the hazard has cleared.
  3. advance & if_valid: load the decoded fields, ex_valid←1.
  4. advance & !if_valid: ex_valid←0.
  5. otherwise (ex_valid & !ex_ready): hold all outputs.
- Latency: one cycle from an accepted input to ex_valid.
- stall_cnt increments on each case-2 cycle and saturates at 2^CNT_W-1. flush does not count.
- Payload fields are don't-care when ex_valid=0; ex_reg_write, ex_mem_write, ex_jump, ex_branch and ex_csr_we are forced 0 when ex_valid=0.
- Reset mid-operation clears state immediately, without waiting for the clock edge.

Optional Feature:
- Macro: ID_EX_ILLEGAL_TRAP_EN.
- Macro defined:
  - An unknown opcode, or if_instr[1:0]≠11, sets ex_illegal=1 and forces reg_write, mem_write, mem_read, jump, branch and csr_we to 0.
  - OP with funct7 other than 0000000/0100000 is also illegal.
- Macro not defined: ex_illegal is tied 0, and unknown opcodes take the default decode.

Test Plan:
- Reset, then addi x5,x0,7 (0x00700293) with ex_ready=1 → next cycle ex_valid=1, alu 0000, srcB 1, reg_write 1, rd 5.
- lw x6,0(x1) then add x7,x6,x2 back-to-back → one bubble (ex_valid=0 for 1 cycle, if_ready=0 that cycle), then add issues, stall_cnt=1.
- lw x6 then addi x0,x6,1 → same bubble, and the addi issues with ex_reg_write=0; lw x0 followed by a use of x0 → no bubble.
- ex_ready=0 for 3 cycles with a held add → outputs stable, if_ready=0; ex_ready=1 → next instruction loads.
- flush=1 while if_valid=1 and a load-use hazard is present → ex_valid=0 next cycle, if_ready=1, stall_cnt unchanged.
- Opcode 0x7F with the macro on → ex_illegal=1, all strobes 0; with the macro off → ex_illegal=0, reg_write=1, rf_wr_sel 11.
